morse2ascii_rx: RTL and testbench

//  Receive side of the Morse link. Samples a keyed on/off line, times marks and gaps in dot units,
//  and rebuilds the 24-bit symbol word (DOT=3'b010, DASH=3'b011, bit2 set on the last symbol,
//  MSB-first). Decodes that word to uppercase ASCII and presents it on a valid/ready output.

---
 rtl/morse2ascii_rx_if.sv | 28 ++
 rtl/morse2ascii_rx.sv | 194 +++++++++++++++++++
 tb/tb_morse2ascii_rx.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/morse2ascii_rx_if.sv
// Character output channel of the Morse receiver: decoded ASCII, symbol word,
// error qualifier and sticky overrun, with a valid/ready handshake.
interface morse2ascii_rx_if;
   logic [7:0]  ascii;
   logic [23:0] morse;
   logic        ascii_valid;
   logic        ascii_ready;
   logic        err;
   logic        overrun;

   modport master (
      output ascii,
      output morse,
      output ascii_valid,
      output err,
      output overrun,
      input  ascii_ready
   );

   modport slave (
      input  ascii,
      input  morse,
      input  ascii_valid,
      input  err,
      input  overrun,
      output ascii_ready
   );
endinterface

// File: rtl/morse2ascii_rx.sv
// Morse receiver: times marks/gaps on a keyed line, rebuilds the symbol word and decodes it to ASCII.
// Optional build macro MORSE_RX_DEGLITCH_EN adds a stability filter on the synchronized key.
module morse2ascii_rx #(
   parameter int unsigned UNIT_CYCLES = 4
`ifdef MORSE_RX_DEGLITCH_EN
   , parameter int unsigned DEGLITCH_CYCLES = 2
`endif
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   key,
   morse2ascii_rx_if.master       sink
);
   localparam int unsigned DASH_MIN   = 2 * UNIT_CYCLES;
   localparam int unsigned LETTER_GAP = 2 * UNIT_CYCLES;
   localparam int unsigned WORD_GAP   = 5 * UNIT_CYCLES;
   localparam int unsigned CW         = $clog2(WORD_GAP + 1);
   localparam logic [CW-1:0] DASH_MIN_C   = CW'(DASH_MIN);
   localparam logic [CW-1:0] LETTER_GAP_C = CW'(LETTER_GAP);
   localparam logic [CW-1:0] WORD_GAP_C   = CW'(WORD_GAP);

   typedef enum logic [1:0] {IDLE, MARK, SPACE, WORDGAP} state_t;

   logic [1:0]    sync;
   logic          k_s;
   state_t        state_q, state_d;
   logic [CW-1:0] mark_cnt, gap_cnt;
   logic [23:0]   sym, sym_last;
   logic [7:0]    code, dec;
   logic [3:0]    sym_n;
   logic          too_long, dec_err, is_dash;
   logic          mark_start, append, emit_letter, emit_space, emit, load;

   always_ff @(posedge clk) begin
      if (rst) sync <= '0;
      else     sync <= {sync[0], key};
   end

`ifdef MORSE_RX_DEGLITCH_EN
   localparam int unsigned DW = $clog2(DEGLITCH_CYCLES + 1);
   logic [DW-1:0] dg_cnt;
   logic          k_f;

   // Level is accepted only after DEGLITCH_CYCLES consecutive differing samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         k_f    <= 1'b0;
         dg_cnt <= '0;
      end else if (sync[1] == k_f) begin
         dg_cnt <= '0;
      end else if (dg_cnt == DW'(DEGLITCH_CYCLES - 1)) begin
         k_f    <= sync[1];
         dg_cnt <= '0;
      end else begin
         dg_cnt <= dg_cnt + 1'b1;
      end
   end
   assign k_s = k_f;
`else
   assign k_s = sync[1];
`endif

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      mark_start  = 1'b0;
      append      = 1'b0;
      emit_letter = 1'b0;
      emit_space  = 1'b0;
      case (state_q)
         IDLE: if (k_s) begin
            state_d    = MARK;
            mark_start = 1'b1;
         end
         MARK: if (!k_s) begin
            state_d = SPACE;
            append  = 1'b1;
         end
         // A mark arriving on the emit cycle starts the next letter without losing its first cycle.
         SPACE: if (gap_cnt == LETTER_GAP_C) begin
            emit_letter = 1'b1;
            state_d     = k_s ? MARK : WORDGAP;
            mark_start  = k_s;
         end else if (k_s) begin
            state_d    = MARK;
            mark_start = 1'b1;
         end
         WORDGAP: if (k_s) begin
            state_d    = MARK;
            mark_start = 1'b1;
         end else if (gap_cnt == WORD_GAP_C) begin
            emit_space = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign is_dash = (mark_cnt >= DASH_MIN_C);

   always_ff @(posedge clk) begin
      if (rst) begin
         mark_cnt <= '0;
         gap_cnt  <= '0;
      end else begin
         if (mark_start)
            mark_cnt <= CW'(1);
         else if (state_q == MARK && k_s && mark_cnt != WORD_GAP_C)
            mark_cnt <= mark_cnt + 1'b1;
         if (append)
            gap_cnt <= '0;
         else if ((state_q == SPACE || state_q == WORDGAP) && !k_s && gap_cnt != WORD_GAP_C)
            gap_cnt <= gap_cnt + 1'b1;
      end
   end

   // sym holds the encoder-format word; code keeps dashes as 1s, first symbol most significant.
   always_ff @(posedge clk) begin
      if (rst || emit_letter) begin
         sym      <= '0;
         code     <= '0;
         sym_n    <= '0;
         too_long <= 1'b0;
      end else if (append) begin
         if (sym_n == 4'd8) begin
            too_long <= 1'b1;
         end else begin
            for (int unsigned i = 0; i < 8; i++)
               if (4'(i) == sym_n) sym[23-3*i -: 3] <= is_dash ? 3'b011 : 3'b010;
            code  <= {code[6:0], is_dash};
            sym_n <= sym_n + 1'b1;
         end
      end
   end

   always_comb begin
      sym_last = sym;
      for (int unsigned i = 0; i < 8; i++)
         if (4'(i + 1) == sym_n) sym_last[23-3*i] = 1'b1;
   end

   always_comb begin
      case ({sym_n, code})
         {4'd2, 8'b01}:     dec = 8'h41;  {4'd4, 8'b1000}:   dec = 8'h42;  {4'd4, 8'b1010}:   dec = 8'h43;
         {4'd3, 8'b100}:    dec = 8'h44;  {4'd1, 8'b0}:      dec = 8'h45;  {4'd4, 8'b0010}:   dec = 8'h46;
         {4'd3, 8'b110}:    dec = 8'h47;  {4'd4, 8'b0000}:   dec = 8'h48;  {4'd2, 8'b00}:     dec = 8'h49;
         {4'd4, 8'b0111}:   dec = 8'h4A;  {4'd3, 8'b101}:    dec = 8'h4B;  {4'd4, 8'b0100}:   dec = 8'h4C;
         {4'd2, 8'b11}:     dec = 8'h4D;  {4'd2, 8'b10}:     dec = 8'h4E;  {4'd3, 8'b111}:    dec = 8'h4F;
         {4'd4, 8'b0110}:   dec = 8'h50;  {4'd4, 8'b1101}:   dec = 8'h51;  {4'd3, 8'b010}:    dec = 8'h52;
         {4'd3, 8'b000}:    dec = 8'h53;  {4'd1, 8'b1}:      dec = 8'h54;  {4'd3, 8'b001}:    dec = 8'h55;
         {4'd4, 8'b0001}:   dec = 8'h56;  {4'd3, 8'b011}:    dec = 8'h57;  {4'd4, 8'b1001}:   dec = 8'h58;
         {4'd4, 8'b1011}:   dec = 8'h59;  {4'd4, 8'b1100}:   dec = 8'h5A;
         {4'd5, 8'b11111}:  dec = 8'h30;  {4'd5, 8'b01111}:  dec = 8'h31;  {4'd5, 8'b00111}:  dec = 8'h32;
         {4'd5, 8'b00011}:  dec = 8'h33;  {4'd5, 8'b00001}:  dec = 8'h34;  {4'd5, 8'b00000}:  dec = 8'h35;
         {4'd5, 8'b10000}:  dec = 8'h36;  {4'd5, 8'b11000}:  dec = 8'h37;  {4'd5, 8'b11100}:  dec = 8'h38;
         {4'd5, 8'b11110}:  dec = 8'h39;
         {4'd6, 8'b010010}: dec = 8'h22;  {4'd6, 8'b011110}: dec = 8'h27;  {4'd5, 8'b10110}:  dec = 8'h28;
         {4'd6, 8'b101101}: dec = 8'h29;  {4'd5, 8'b01010}:  dec = 8'h2B;  {4'd6, 8'b110011}: dec = 8'h2C;
         {4'd6, 8'b100001}: dec = 8'h2D;  {4'd6, 8'b010101}: dec = 8'h2E;  {4'd5, 8'b10010}:  dec = 8'h2F;
         {4'd6, 8'b111000}: dec = 8'h3A;  {4'd5, 8'b10001}:  dec = 8'h3D;  {4'd6, 8'b001100}: dec = 8'h3F;
         {4'd6, 8'b011010}: dec = 8'h40;
         default:           dec = 8'h00;
      endcase
   end

   assign dec_err = too_long || (dec == 8'h00);
   assign emit    = emit_letter || emit_space;
   assign load    = emit && (!sink.ascii_valid || sink.ascii_ready);

   always_ff @(posedge clk) begin
      if (rst) begin
         sink.ascii       <= '0;
         sink.morse       <= '0;
         sink.err         <= 1'b0;
         sink.ascii_valid <= 1'b0;
         sink.overrun     <= 1'b0;
      end else begin
         if (load) begin
            sink.ascii       <= emit_letter ? (dec_err ? 8'h00 : dec) : 8'h20;
            sink.morse       <= emit_letter ? sym_last : 24'h000100;
            sink.err         <= emit_letter && dec_err;
            sink.ascii_valid <= 1'b1;
         end else if (sink.ascii_valid && sink.ascii_ready) begin
            sink.ascii_valid <= 1'b0;
         end
         if (emit && sink.ascii_valid && !sink.ascii_ready)
            sink.overrun <= 1'b1;
      end
   end
endmodule

// File: tb/tb_morse2ascii_rx.sv
// Self-checking bench for morse2ascii_rx: directed scenarios plus random letters/words
// compared against a table-driven reference of the Morse alphabet.
module tb_morse2ascii_rx;
  typedef struct packed {
    logic [7:0]  a;
    logic [23:0] m;
    logic        e;
  } rec_t;

  localparam rec_t SPACE_REC = '{a: 8'h20, m: 24'h000100, e: 1'b0};

  logic clk = 1'b0;
  logic rst;
  logic key;
  int unsigned total = 0;
  int unsigned bad = 0;
  rec_t got_q[$];
  rec_t exp_q[$];

  string codes [49] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                        "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                        "..-", "...-", ".--", "-..-", "-.--", "--..",
                        "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
                        "---..", "----.",
                        ".-..-.", ".----.", "-.--.", "-.--.-", ".-.-.", "--..--", "-....-",
                        ".-.-.-", "-..-.", "---...", "-...-", "..--..", ".--.-."};
  string chars_a = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";
  string chars_b = "'()+,-./:=?@";

  morse2ascii_rx_if bus ();

  morse2ascii_rx #(.UNIT_CYCLES(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .key  (key),
    .sink (bus)
  );

  always #5 clk = ~clk;

  // Records every character the sink accepts, sampled after the inputs settle.
  always @(negedge clk) begin
    #1;
    if (!rst && bus.ascii_valid && bus.ascii_ready)
      got_q.push_back('{a: bus.ascii, m: bus.morse, e: bus.err});
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] char_of(input int unsigned j);
    if (j < 36)       return chars_a[j];
    else if (j == 36) return 8'h22;
    else              return chars_b[j - 37];
  endfunction

  function automatic rec_t model(input string s);
    rec_t        r;
    int unsigned n, eff;
    logic [23:0] w;
    logic [2:0]  v;
    n   = s.len();
    eff = (n > 8) ? 8 : n;
    w   = '0;
    for (int unsigned i = 0; i < eff; i++) begin
      v = (s[i] == "-") ? 3'd3 : 3'd2;
      if (i == eff - 1) v = v + 3'd4;
      w = w | (24'(v) << (21 - 3 * i));
    end
    r.a = 8'h00;
    if (n <= 8)
      for (int unsigned j = 0; j < 49; j++)
        if (codes[j] == s) r.a = char_of(j);
    r.m = w;
    r.e = (r.a == 8'h00);
    return r;
  endfunction

  task automatic send_letter(input string s, input bit rnd, input int unsigned lgap);
    int unsigned nm, ng;
    for (int unsigned i = 0; i < s.len(); i++) begin
      key = 1'b1;
      if (s[i] == "-") nm = rnd ? $urandom_range(14, 10) : 12;
      else             nm = rnd ? $urandom_range(5, 1) : 4;
      repeat (nm) @(negedge clk);
      key = 1'b0;
      ng = (i == s.len() - 1) ? lgap : (rnd ? $urandom_range(5, 1) : 4);
      repeat (ng) @(negedge clk);
    end
    exp_q.push_back(model(s));
    if (lgap >= 30) exp_q.push_back(SPACE_REC);
  endtask

  task automatic check_q(input string tag);
    int unsigned lim = 0;
    while (got_q.size() < exp_q.size() && lim < 400) begin
      @(negedge clk);
      lim++;
    end
    repeat (4) @(negedge clk);
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int unsigned i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int unsigned lat;
    string s;
    rst = 1'b1;
    key = 1'b0;
    bus.ascii_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_ascii", 64'(bus.ascii), 64'h00);
    check("rst_morse", 64'(bus.morse), 64'h0);
    check("rst_valid", 64'(bus.ascii_valid), 64'h0);
    check("rst_err", 64'(bus.err), 64'h0);
    check("rst_overrun", 64'(bus.overrun), 64'h0);
    repeat (2) @(negedge clk);

    // 'E' with latency of the letter and of the following word space
    key = 1'b1;
    repeat (4) @(negedge clk);
    key = 1'b0;
    @(posedge clk);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus.ascii_valid && lat < 40);
    check("e_latency", 64'(lat), 64'd11);
    check("e_ascii", 64'(bus.ascii), 64'h45);
    check("e_morse", 64'(bus.morse), 64'hC00000);
    check("e_err", 64'(bus.err), 64'h0);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!(bus.ascii_valid && bus.ascii == 8'h20) && lat < 60);
    check("space_delay", 64'(lat), 64'd12);
    check("space_morse", 64'(bus.morse), 64'h000100);
    exp_q.push_back('{a: 8'h45, m: 24'hC00000, e: 1'b0});
    exp_q.push_back(SPACE_REC);
    repeat (10) @(negedge clk);
    check_q("e_seq");

    send_letter(".-", 1'b0, 40);
    check_q("a_seq");

    send_letter("-", 1'b0, 12);
    send_letter(".", 1'b0, 40);
    check_q("te_seq");

    send_letter(".........", 1'b0, 40);
    check_q("nine_dots");

    // Sink stalled: 'T' held, 'E' and the space dropped
    bus.ascii_ready = 1'b0;
    send_letter("-", 1'b0, 12);
    send_letter(".", 1'b0, 40);
    exp_q.delete();
    check("ovr_ascii", 64'(bus.ascii), 64'h54);
    check("ovr_morse", 64'(bus.morse), 64'hE00000);
    check("ovr_valid", 64'(bus.ascii_valid), 64'h1);
    check("ovr_flag", 64'(bus.overrun), 64'h1);
    bus.ascii_ready = 1'b1;
    @(posedge clk); #1;
    check("ovr_valid_fall", 64'(bus.ascii_valid), 64'h0);
    check("ovr_sticky", 64'(bus.overrun), 64'h1);
    exp_q.push_back('{a: 8'h54, m: 24'hE00000, e: 1'b0});
    @(negedge clk);
    check_q("ovr_seq");

    // Reset in the middle of the dash of 'A'
    key = 1'b1;
    repeat (4) @(negedge clk);
    key = 1'b0;
    repeat (4) @(negedge clk);
    key = 1'b1;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    key = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_out", {bus.ascii, bus.morse, bus.err, bus.ascii_valid, bus.overrun}, 64'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    send_letter(".", 1'b0, 40);
    check_q("after_rst");

    // Random words from the alphabet, unknown 7-symbol patterns and over-long dot runs
    for (int unsigned w = 0; w < 10; w++) begin
      int unsigned nl;
      nl = $urandom_range(3, 1);
      for (int unsigned l = 0; l < nl; l++) begin
        int unsigned r;
        r = $urandom_range(9, 0);
        if (r < 8) begin
          s = codes[$urandom_range(48, 0)];
        end else if (r == 8) begin
          s = "";
          for (int unsigned k = 0; k < 7; k++) s = {s, ($urandom_range(1, 0) != 0) ? "-" : "."};
        end else begin
          int unsigned nd;
          nd = $urandom_range(10, 9);
          s = "";
          for (int unsigned k = 0; k < nd; k++) s = {s, "."};
        end
        send_letter(s, 1'b1, (l == nl - 1) ? 40 : $urandom_range(16, 12));
      end
    end
    check_q("rand");
    check("final_overrun", 64'(bus.overrun), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
